regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 35 +++
 rtl/regfile_sb.sv | 130 +++++++++++++
 tb/tb_regfile_sb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bundles the write, scoreboard, clear and read signals of the register file.
// The bench drives through "master" and the register file receives through "slave".
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              clr_req;
  logic              busy;
  logic              wen0;
  logic [ADDR_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic              wen1;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;
  logic              sb_set;
  logic [ADDR_W-1:0] sb_addr;
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic              rready_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic              rready_b;

  modport master (
    output clr_req, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
           sb_set, sb_addr, raddr_a, raddr_b,
    input  busy, rdata_a, rready_a, rdata_b, rready_b
  );

  modport slave (
    input  clr_req, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
           sb_set, sb_addr, raddr_a, raddr_b,
    output busy, rdata_a, rready_a, rdata_b, rready_b
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-write / two-read register file with a per-entry pending scoreboard and a
// walking clear; reads are combinational, writes land at the next edge, busy stalls nothing.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic              w_idle;
  logic              w_we0;
  logic              w_we1;
  logic              w_set;
  logic [ADDR_W-1:0] w_raddr [2];
  logic [DATA_W-1:0] w_rdata [2];
  logic              w_rrdy  [2];

  assign w_idle = (r_state == IDLE);

  // Entry 0 is dropped here so stores, scoreboard and bypass all see it as untouched.
  assign w_we0 = w_idle && bus.wen0 && !(ZERO_REG != 0 && bus.waddr0 == '0);
  assign w_we1 = w_idle && bus.wen1 && !(ZERO_REG != 0 && bus.waddr1 == '0);
  assign w_set = w_idle && bus.sb_set && !(ZERO_REG != 0 && bus.sb_addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.clr_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy = (r_state == CLEAR);

  // Data array carries no reset; only the walk zeroes it.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (!rst) begin
      if (w_we0 && !(w_we1 && bus.waddr1 == bus.waddr0)) begin
        r_mem[bus.waddr0] <= bus.wdata0;
      end
      if (w_we1) begin
        r_mem[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  // Set is applied last so it wins over a same-cycle write to the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else if (r_state == CLEAR) begin
      r_pend[r_cnt] <= 1'b0;
    end else begin
      if (w_we0) r_pend[bus.waddr0] <= 1'b0;
      if (w_we1) r_pend[bus.waddr1] <= 1'b0;
      if (w_set) r_pend[bus.sb_addr] <= 1'b1;
    end
  end

  assign w_raddr[0] = bus.raddr_a;
  assign w_raddr[1] = bus.raddr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = '0;
      w_rrdy[p]  = 1'b0;
      if (!w_idle) begin
        w_rdata[p] = '0;
        w_rrdy[p]  = 1'b0;
      end else if (ZERO_REG != 0 && w_raddr[p] == '0) begin
        w_rdata[p] = '0;
        w_rrdy[p]  = 1'b1;
      end else if (BYPASS != 0 && w_we1 && bus.waddr1 == w_raddr[p]) begin
        w_rdata[p] = bus.wdata1;
        w_rrdy[p]  = 1'b1;
      end else if (BYPASS != 0 && w_we0 && bus.waddr0 == w_raddr[p]) begin
        w_rdata[p] = bus.wdata0;
        w_rrdy[p]  = 1'b1;
      end else begin
        w_rdata[p] = r_mem[w_raddr[p]];
        w_rrdy[p]  = !r_pend[w_raddr[p]];
      end
    end
  end

  assign bus.rdata_a  = w_rdata[0];
  assign bus.rready_a = w_rrdy[0];
  assign bus.rdata_b  = w_rdata[1];
  assign bus.rready_b = w_rrdy[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus pushes expected read/busy values into a
// queue, and a negedge monitor pops and compares them against the live outputs.
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk;
  logic rst;

  regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;   // 0 rdata_a, 1 rready_a, 2 rdata_b, 3 rready_b, 4 busy
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        0:       act = bus.rdata_a;
        1:       act = {31'b0, bus.rready_a};
        2:       act = bus.rdata_b;
        3:       act = {31'b0, bus.rready_b};
        default: act = {31'b0, bus.busy};
      endcase
      n_tests++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
      end
    end
  end

  task automatic check_now(input logic [31:0] act, input logic [31:0] exp, input string name);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int sel, input logic [31:0] val, input string name);
    exp_t e;
    e.sel = sel; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic chk_a(input logic [31:0] d, input logic r, input string name);
    expect_v(0, d, {name, " rdata_a"});
    expect_v(1, {31'b0, r}, {name, " rready_a"});
  endtask

  task automatic chk_b(input logic [31:0] d, input logic r, input string name);
    expect_v(2, d, {name, " rdata_b"});
    expect_v(3, {31'b0, r}, {name, " rready_b"});
  endtask

  task automatic idle_inputs();
    bus.clr_req = 1'b0;
    bus.wen0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.wen1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0;
  endtask

  task automatic busy_window(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      expect_v(4, 32'd1, name);
      tick();
    end
    expect_v(4, 32'd0, {name, " fall"});
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    idle_inputs();
    bus.raddr_a = '0;
    bus.raddr_b = '0;
    tick(); tick(); tick();

    // Held in reset: clear state, reads blocked.
    bus.raddr_a = 5'd4;
    bus.raddr_b = 5'd9;
    #1;
    check_now({31'b0, bus.busy}, 32'd1, "reset state busy");
    check_now(bus.rdata_a, 32'd0, "reset state rdata_a");
    check_now({31'b0, bus.rready_a}, 32'd0, "reset state rready_a");
    expect_v(4, 32'd1, "reset busy");
    chk_a(32'd0, 1'b0, "reset read");
    chk_b(32'd0, 1'b0, "reset read");
    rst = 1'b0;
    busy_window("post-reset busy");
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      bus.raddr_a = ADDR_W'(i);
      bus.raddr_b = ADDR_W'(DEPTH - 1 - i);
      chk_a(32'd0, 1'b1, "walked read");
      chk_b(32'd0, 1'b1, "walked read");
      tick();
    end

    // Dual write to the same entry: port 1 wins, bypass and stored.
    bus.wen0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'h11;
    bus.wen1 = 1'b1; bus.waddr1 = 5'd5; bus.wdata1 = 32'h22;
    bus.raddr_a = 5'd5; bus.raddr_b = 5'd5;
    chk_a(32'h22, 1'b1, "conflict bypass");
    chk_b(32'h22, 1'b1, "conflict bypass");
    tick();
    idle_inputs();
    chk_a(32'h22, 1'b1, "conflict stored");
    tick();

    // Scoreboard set on 7, then a write clears it.
    bus.sb_set = 1'b1; bus.sb_addr = 5'd7; bus.raddr_a = 5'd7;
    chk_a(32'd0, 1'b1, "sb_set same cycle");
    tick();
    idle_inputs();
    chk_a(32'd0, 1'b0, "sb pending");
    tick();
    bus.wen0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'hABCD;
    chk_a(32'hABCD, 1'b1, "sb write bypass");
    tick();
    idle_inputs();
    chk_a(32'hABCD, 1'b1, "sb write after");
    tick();

    // Set wins over a same-cycle write.
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    bus.wen0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h55;
    bus.raddr_b = 5'd9;
    chk_b(32'h55, 1'b1, "set+write bypass");
    tick();
    idle_inputs();
    chk_b(32'h55, 1'b0, "set wins");
    tick();
    bus.wen1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h66;
    tick();
    idle_inputs();
    chk_b(32'h66, 1'b1, "port1 clears pending");
    tick();

    // Entry 0 is hardwired zero.
    bus.wen0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFF_FFFF;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0; bus.raddr_a = 5'd0;
    chk_a(32'd0, 1'b1, "zero reg no bypass");
    tick();
    idle_inputs();
    chk_a(32'd0, 1'b1, "zero reg stored");
    tick();

    // Independent writes on both ports, each read bypasses its own.
    bus.wen0 = 1'b1; bus.waddr0 = 5'd10; bus.wdata0 = 32'hAA;
    bus.wen1 = 1'b1; bus.waddr1 = 5'd11; bus.wdata1 = 32'hBB;
    bus.raddr_a = 5'd10; bus.raddr_b = 5'd11;
    chk_a(32'hAA, 1'b1, "port0 bypass");
    chk_b(32'hBB, 1'b1, "port1 bypass");
    tick();
    idle_inputs();
    chk_a(32'hAA, 1'b1, "port0 stored");
    chk_b(32'hBB, 1'b1, "port1 stored");
    tick();

    // Clear walk with a dropped write, dropped sb_set and an ignored second clr_req.
    bus.wen0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h33;
    tick();
    idle_inputs();
    bus.raddr_a = 5'd3;
    chk_a(32'h33, 1'b1, "pre-clear value");
    bus.clr_req = 1'b1;
    expect_v(4, 32'd0, "busy on clr_req cycle");
    tick();
    idle_inputs();
    bus.raddr_b = 5'd12;
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      if (i == 20) begin
        bus.wen0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h77;
      end
      if (i == 25) begin
        bus.sb_set = 1'b1; bus.sb_addr = 5'd12;
      end
      if (i == 10) bus.clr_req = 1'b1;
      expect_v(4, 32'd1, "clear busy");
      if (i == 20) chk_a(32'd0, 1'b0, "read during clear");
      tick();
    end
    idle_inputs();
    expect_v(4, 32'd0, "clear busy fall");
    chk_a(32'd0, 1'b1, "dropped write");
    chk_b(32'd0, 1'b1, "dropped sb_set");
    bus.wen0 = 1'b1; bus.waddr0 = 5'd4; bus.wdata0 = 32'h44;
    tick();
    idle_inputs();
    bus.raddr_a = 5'd4;
    chk_a(32'h44, 1'b1, "write as busy falls");
    tick();

    // Reset mid-walk restarts the full walk.
    bus.clr_req = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    busy_window("restart busy");
    tick();

    waited = 0;
    while (bus.busy === 1'b1 && waited < DEPTH + 4) begin
      tick();
      waited++;
    end
    check_now({31'b0, bus.busy}, 32'd0, "restart walk wait expired");

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
